// File: rtl/scan_scheduler.sv
// Two-axis LDR scan sequencer: sweeps base then arm, parks both at the brightest angle.
// Optional macro LDR_AVG_EN: sums the last 4 dwell samples per angle instead of a single sample.
module scan_scheduler #(
    parameter int unsigned ANGLE_MAX  = 180,
    parameter int unsigned LDR_W      = 10,
    parameter int unsigned SETTLE_CYC = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic [LDR_W-1:0] ldr,
    input  logic [31:0]      speed,
    input  logic [31:0]      rescan_period,
    output logic [7:0]       base,
    output logic [7:0]       arm,
    output logic             status,
    output logic             busy,
    output logic [LDR_W-1:0] max_ldr
);

`ifdef LDR_AVG_EN
    localparam int unsigned SW = LDR_W + 2;
`else
    localparam int unsigned SW = LDR_W;
`endif

    typedef enum logic [2:0] {IDLE, SETTLE_B, SWEEP_B, SETTLE_A, SWEEP_A} state_t;

    state_t        state, state_next;
    logic          trig_q;
    logic [31:0]   idle_cnt;
    logic [31:0]   dwell;
    logic [31:0]   dwell_start;
    logic [31:0]   cnt;
    logic [SW-1:0] max_i;
    logic [7:0]    max_b, max_a;
    logic [SW-1:0] sample;
    logic [SW-1:0] fin_i;
    logic [7:0]    cur_angle;
    logic          start, settle_done, last_dwell, last_angle, better;

`ifdef LDR_AVG_EN
    logic [SW-1:0] acc;
`endif

    always_comb begin
        start       = 1'b0;
        settle_done = (cnt == SETTLE_CYC - 32'd1);
        last_dwell  = (cnt == dwell - 32'd1);
        cur_angle   = (state == SWEEP_A) ? arm : base;
        last_angle  = (cur_angle == 8'(ANGLE_MAX));
`ifdef LDR_AVG_EN
        dwell_start = (speed < 32'd4) ? 32'd4 : speed;
        sample      = acc + SW'(ldr);
`else
        dwell_start = (speed == 32'd0) ? 32'd1 : speed;
        sample      = ldr;
`endif
        better      = (sample > max_i);
        fin_i       = better ? sample : max_i;
        if (state == IDLE) begin
            // A coincident trigger edge and timer match still yield a single start.
            start = (trigger && !trig_q) ||
                    ((rescan_period != 32'd0) && (idle_cnt >= rescan_period - 32'd1));
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = SETTLE_B;
            SETTLE_B: if (settle_done) state_next = SWEEP_B;
            SWEEP_B:  if (last_dwell && last_angle) state_next = SETTLE_A;
            SETTLE_A: if (settle_done) state_next = SWEEP_A;
            SWEEP_A:  if (last_dwell && last_angle) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q   <= 1'b0;
            idle_cnt <= '0;
            dwell    <= 32'd1;
            cnt      <= '0;
            max_i    <= '0;
            max_b    <= '0;
            max_a    <= '0;
            base     <= '0;
            arm      <= '0;
            status   <= 1'b0;
            busy     <= 1'b0;
            max_ldr  <= '0;
        end else begin
            trig_q <= trigger;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        status   <= 1'b0;
                        base     <= '0;
                        arm      <= '0;
                        dwell    <= dwell_start;
                        max_i    <= '0;
                        max_b    <= '0;
                        max_a    <= '0;
                        idle_cnt <= '0;
                        cnt      <= '0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end
                SETTLE_B, SETTLE_A: begin
                    cnt <= settle_done ? 32'd0 : cnt + 32'd1;
                end
                SWEEP_B: begin
                    if (last_dwell) begin
                        cnt <= '0;
                        if (better) begin
                            max_i <= sample;
                            max_b <= base;
                        end
                        if (last_angle) begin
                            base  <= better ? base : max_b;
                            arm   <= '0;
                            max_i <= '0;
                            max_a <= '0;
                        end else begin
                            base <= base + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                SWEEP_A: begin
                    if (last_dwell) begin
                        cnt <= '0;
                        if (better) begin
                            max_i <= sample;
                            max_a <= arm;
                        end
                        if (last_angle) begin
                            arm    <= better ? arm : max_a;
`ifdef LDR_AVG_EN
                            max_ldr <= fin_i[SW-1:2];
`else
                            max_ldr <= fin_i;
`endif
                            status <= 1'b1;
                            busy   <= 1'b0;
                        end else begin
                            arm <= arm + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LDR_AVG_EN
    // Accumulate only the final four dwell cycles; cleared as each angle completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (state == SWEEP_B || state == SWEEP_A) begin
            if (last_dwell)
                acc <= '0;
            else if (cnt >= dwell - 32'd4)
                acc <= acc + SW'(ldr);
        end else begin
            acc <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_scan_scheduler.sv
// Scoreboard bench for scan_scheduler: stimulus pushes expected scan results, a monitor checks each status rise.
module tb_scan_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trigger = 1'b0;
    logic [9:0]  ldr;
    logic [31:0] speed = 32'd1;
    logic [31:0] rescan_period = 32'd0;
    logic [7:0]  base, arm;
    logic        status, busy;
    logic [9:0]  max_ldr;

    scan_scheduler #(.ANGLE_MAX(180), .LDR_W(10), .SETTLE_CYC(4)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .ldr(ldr), .speed(speed),
        .rescan_period(rescan_period), .base(base), .arm(arm), .status(status),
        .busy(busy), .max_ldr(max_ldr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int b;
        int a;
        int mx;
        int len;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_starts = 0;

    // Light source: peak 900 at base=90/arm=45, falling 1 per degree on each axis; or a constant.
    bit ldr_model = 1'b1;
    int ldr_const = 0;
    always @* begin
        int v, db, da;
        db = int'(base) - 90;
        da = int'(arm) - 45;
        if (db < 0) db = -db;
        if (da < 0) da = -da;
        v = 900 - db - da;
        if (v < 0) v = 0;
        ldr = ldr_model ? 10'(v) : 10'(ldr_const);
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int exp_len(int s);
        int d;
        d = s;
`ifdef LDR_AVG_EN
        if (d < 4) d = 4;
`else
        if (d < 1) d = 1;
`endif
        return 2 * (4 + 181 * d);
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: pairs each busy rise with its status rise and checks against the queue head.
    bit busy_q = 1'b0, status_q = 1'b0, have_status = 1'b0;
    int t_busy = 0, t_status = 0, cur_gap = -1;
    always @(negedge clk) begin
        exp_t e;
        if (busy && !busy_q) begin
            n_starts++;
            t_busy  = cyc;
            cur_gap = have_status ? cyc - t_status : -1;
        end
        if (status && !status_q) begin
            t_status    = cyc;
            have_status = 1'b1;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_scan: got status rise expected none");
            end else begin
                e = exp_q.pop_front();
                check("park_base", int'(base), e.b);
                check("park_arm", int'(arm), e.a);
                check("max_ldr", int'(max_ldr), e.mx);
                check("scan_len", cyc - t_busy, e.len);
                if (e.gap >= 0) check("rescan_gap", cur_gap, e.gap);
            end
        end
        busy_q   = busy;
        status_q = status;
    end

    task automatic push(input int b, input int a, input int mx, input int len, input int gap);
        exp_t e;
        e.b = b; e.a = a; e.mx = mx; e.len = len; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic pulse_trigger();
        @(negedge clk) trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
    endtask

    task automatic wait_drain(input int limit, input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_busy(input int limit, input string name);
        int k;
        k = 0;
        while (!busy && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(busy), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_base"}, int'(base), 0);
        check({tag, "_arm"}, int'(arm), 0);
        check({tag, "_status"}, int'(status), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_max_ldr"}, int'(max_ldr), 0);
    endtask

    initial begin
        int k, starts0;

        // 1. Reset values and no spontaneous scan
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst");
        repeat (200) @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_starts", n_starts, 0);

        // 2. Peak search, speed=2
        speed = 32'd2;
        ldr_model = 1'b1;
        push(90, 45, 900, 732, -1);
        pulse_trigger();
        wait_drain(2000, "scan2_done");

        // 3. Flat light: ties keep angle 0
        speed = 32'd1;
        ldr_model = 1'b0;
        ldr_const = 500;
        push(0, 0, 500, exp_len(1), -1);
        pulse_trigger();
        wait_drain(4000, "scan3a_done");
        ldr_const = 0;
        push(0, 0, 0, exp_len(1), -1);
        pulse_trigger();
        wait_drain(4000, "scan3b_done");

        // 4. Periodic rescans; triggers while busy are dropped
        ldr_model = 1'b1;
        rescan_period = 32'd1000;
        starts0 = n_starts;
        push(90, 45, 900, exp_len(1), 1000);
        push(90, 45, 900, exp_len(1), 1000);
        wait_busy(1100, "auto_start");
        repeat (50) @(negedge clk);
        pulse_trigger();
        repeat (100) @(negedge clk);
        pulse_trigger();
        wait_drain(5000, "auto_done");
        rescan_period = 32'd0;
        repeat (10) @(negedge clk);
        check("auto_starts", n_starts - starts0, 2);

        // 5. Reset mid-sweep aborts; next scan is clean
        speed = 32'd1;
        push(90, 45, 900, exp_len(1), -1);
        pulse_trigger();
        k = 0;
        while (!(busy && base == 8'd60) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("reach_base60", int'(base), 60);
        exp_q.delete();
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push(90, 45, 900, exp_len(1), -1);
        pulse_trigger();
        wait_drain(4000, "scan5_done");

        // 6. speed=0 clamps; mid-scan speed change ignored
        speed = 32'd0;
        push(90, 45, 900, exp_len(0), -1);
        pulse_trigger();
        wait_busy(20, "scan6_start");
        repeat (20) @(negedge clk);
        speed = 32'd5;
        wait_drain(4000, "scan6a_done");
        speed = 32'd1;
        push(90, 45, 900, exp_len(1), -1);
        pulse_trigger();
        wait_drain(4000, "scan6b_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
